// File: rtl/i2s_pkg.sv
// Shared constants for the I2S DAC transmitter.
// Frame geometry, channel tags and FSM state encoding.
package i2s_pkg;

    localparam int FRAME_BITS      = 64;
    localparam int SLOT_BITS       = 32;
    localparam int SAMPLE_BITS_DEF = 24;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous in-order word buffer feeding the I2S transmitter.
// Each entry holds the channel tag in the top bit above the word.
module i2s_tx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     sck,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sck) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: buffers tagged words and serialises one sample per
// 32-sck slot, left on ws=0 and right on ws=1, with one-bit MSB delay.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic        data_ch,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        ws,
    output logic        sd,
    output logic        underrun
);

    logic [0:0]             state;
    logic [5:0]             cnt;
    logic [5:0]             cnt_next;
    logic [SAMPLE_BITS-1:0] shreg;
    logic                   run_next;
    logic                   load;
    logic                   hit;
    logic [32:0]            head;
    logic                   full;
    logic                   empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                   unused_ok;

    assign ready_out = !full;
    assign unused_ok = ^{head[31-SAMPLE_BITS:0], fifo_cnt};

    i2s_tx_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sck     (sck),
        .rst     (rst),
        .wr_en   (valid_in),
        .wr_data ({data_ch, data_in}),
        .rd_en   (hit),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_cnt)
    );

    // A slot loads on the edge that starts p=0; its channel is the new ws.
    always_comb begin
        run_next = (state == RUN) || start;
        cnt_next = (state == RUN) ? cnt + 6'd1 : 6'd0;
        load     = run_next && (cnt_next[4:0] == 5'd0);
        hit      = load && !empty && (head[32] == cnt_next[5]);
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ws       <= 1'b0;
            sd       <= 1'b0;
            underrun <= 1'b0;
            shreg    <= '0;
        end else if (run_next) begin
            state <= RUN;
            cnt   <= cnt_next;
            ws    <= cnt_next[5];
            if (load) begin
                shreg    <= hit ? head[31 -: SAMPLE_BITS] : '0;
                sd       <= 1'b0;
                underrun <= !hit;
            end else begin
                shreg    <= {shreg[SAMPLE_BITS-2:0], 1'b0};
                sd       <= shreg[SAMPLE_BITS-1];
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: pushes record the slot each sample
// should occupy; a negedge monitor deserialises sd and checks each slot.
module tb_i2s_dac_tx;

    logic        sck = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic        data_ch;
    logic        valid_in;
    logic        ready_out;
    logic        ws;
    logic        sd;
    logic        underrun;

    i2s_dac_tx #(
        .SAMPLE_BITS (24),
        .FIFO_DEPTH  (4)
    ) dut (
        .sck       (sck),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .data_ch   (data_ch),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .ws        (ws),
        .sd        (sd),
        .underrun  (underrun)
    );

    always #5 sck = ~sck;

    typedef struct {
        int          slot;
        logic [23:0] smp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last   = -1;
    logic tb_run = 1'b0;
    int   per    = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference timeline: period index since the start edge.
    always @(posedge sck or posedge rst) begin
        if (rst) begin
            tb_run <= 1'b0;
            per    <= 0;
        end else if (tb_run) begin
            per <= per + 1;
        end else if (start) begin
            tb_run <= 1'b1;
            per    <= 0;
        end
    end

    logic [31:0] acc;
    logic        und0;
    logic        bad_und;
    logic        bad_ws;

    always @(negedge sck) begin
        if (!tb_run) begin
            chk("idle_out", {61'd0, ws, sd, underrun}, 64'd0);
        end else begin
            automatic int n = per % 64;
            automatic int p = n % 32;
            automatic int s = per / 32;
            automatic logic [31:0] exp_acc = 32'd0;
            automatic logic exp_u = 1'b1;
            if (p == 0) begin
                acc     = 32'd0;
                und0    = underrun;
                bad_und = 1'b0;
                bad_ws  = 1'b0;
            end else if (underrun) begin
                bad_und = 1'b1;
            end
            if (ws !== ((n >= 32) ? 1'b1 : 1'b0)) bad_ws = 1'b1;
            acc = {acc[30:0], sd};
            if (p == 31) begin
                while (exp_q.size() > 0 && exp_q[0].slot < s) begin
                    chk("stale_slot", 64'(exp_q[0].slot), 64'(s));
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].slot == s) begin
                    exp_acc = {1'b0, exp_q[0].smp, 7'd0};
                    exp_u   = 1'b0;
                    void'(exp_q.pop_front());
                end
                chk($sformatf("slot%0d_data", s), 64'(acc), 64'(exp_acc));
                chk($sformatf("slot%0d_flags", s),
                    {61'd0, und0, bad_und, bad_ws}, {61'd0, exp_u, 2'b00});
            end
        end
    end

    // Caller is between edges; returns how many edges the word waited.
    task automatic push(input logic ch, input logic [31:0] w, output int waits);
        automatic int cur;
        automatic int s;
        valid_in = 1'b1;
        data_in  = w;
        data_ch  = ch;
        waits    = 0;
        while (!ready_out && waits < 200) begin
            @(negedge sck);
            waits++;
        end
        if (waits >= 200) chk("push_timeout", 64'(waits), 64'd0);
        @(posedge sck);
        #1;
        valid_in = 1'b0;
        cur = tb_run ? per / 32 : -1;
        s = ((last > cur) ? last : cur) + 1;
        if ((s % 2) != int'(ch)) s++;
        last = s;
        exp_q.push_back('{slot: s, smp: w[31:8]});
    endtask

    task automatic wait_per(input int target);
        automatic int b = 0;
        while (!(tb_run && per >= target) && b < 2000) begin
            @(negedge sck);
            b++;
        end
        if (b >= 2000) chk("wait_timeout", 64'(target), 64'(per));
    endtask

    logic [31:0] pair_l [4] = '{32'hDEADBE11, 32'h7FFFFF00, 32'h00000000, 32'hC0FFEE55};
    logic [31:0] pair_r [4] = '{32'h0123457F, 32'h80000000, 32'hFFFFFFFF, 32'hA5A5A5A5};

    initial begin
        automatic int w = 0;
        automatic int base;
        rst      = 1'b1;
        start    = 1'b0;
        data_in  = 32'd0;
        data_ch  = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(negedge sck);
        chk("rst_ready", {63'd0, ready_out}, 64'd1);
        chk("rst_out", {61'd0, ws, sd, underrun}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge sck);

        push(1'b0, 32'hABCDEF00, w);
        chk("ready_1", {63'd0, ready_out}, 64'd1);
        push(1'b1, 32'h12345600, w);
        chk("ready_2", {63'd0, ready_out}, 64'd1);
        push(1'b0, 32'h800001FF, w);
        chk("ready_3", {63'd0, ready_out}, 64'd1);
        push(1'b1, 32'hFFFFFFFF, w);
        chk("ready_full", {63'd0, ready_out}, 64'd0);
        repeat (3) @(negedge sck);
        chk("hold_full", {63'd0, ready_out}, 64'd0);
        start = 1'b1;
        push(1'b0, 32'h000001AA, w);
        chk("fifth_waits", 64'(w), 64'd1);

        wait_per(168);
        push(1'b1, 32'h00000100, w);
        push(1'b0, 32'h55AA5500, w);
        push(1'b1, 32'h0F0F0FEE, w);
        for (int i = 0; i < 4; i++) begin
            push(1'b0, pair_l[i], w);
            push(1'b1, pair_r[i], w);
        end

        base = (last / 2 + 1) * 64;
        wait_per(base + 33);
        push(1'b0, 32'h11111100, w);
        push(1'b1, 32'h22222200, w);
        push(1'b0, 32'h33333300, w);
        wait_per(base + 40);
        #2;
        start = 1'b0;
        rst   = 1'b1;
        #1;
        chk("midrst_out", {61'd0, ws, sd, underrun}, 64'd0);
        chk("midrst_ready", {63'd0, ready_out}, 64'd1);
        exp_q.delete();
        last = -1;
        repeat (3) @(negedge sck);
        rst = 1'b0;
        repeat (4) @(negedge sck);
        start = 1'b1;
        wait_per(130);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
